// File: rtl/uart_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_framer
// Purpose  : UART transmitter with baud timer, parity/stop options and a
//            one-entry holding register for gap-free back-to-back frames.
// Revision : 1.0
// ============================================================================
module uart_tx_framer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 busy,
    output logic                 done
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] c_last   = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] c_penult = TW'(CLKS_PER_BIT - 2);
    localparam logic [BW-1:0] c_dlast  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] c_slast  = BW'(STOP_BITS - 1);
    localparam logic          c_odd    = (PARITY == 1);

    if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
        $error("uart_tx_framer: illegal parameter value");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t               r_state;
    logic [TW-1:0]        r_timer;
    logic [BW-1:0]        r_bitcnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_hold;
    logic                 r_hold_full;
    logic                 r_parity;
    logic                 r_tx;
    logic                 r_done;

    logic                 w_accept;
    logic                 w_bit_end;
    logic                 w_frame_end;
    logic                 w_load;
    logic                 w_to_hold;
    logic [DATA_BITS-1:0] w_load_word;

    assign w_accept    = tx_valid & ~r_hold_full;
    assign w_bit_end   = (r_state != S_IDLE) && (r_timer == c_last);
    assign w_frame_end = (r_state == S_STOP) && w_bit_end && (r_bitcnt == c_slast);
    // A word accepted on the frame-end edge (holding register empty) starts
    // directly, so it never sits in the holding register and ready stays high.
    assign w_load      = ((r_state == S_IDLE) && w_accept) ||
                         (w_frame_end && (r_hold_full || w_accept));
    assign w_load_word = r_hold_full ? r_hold : tx_data;
    assign w_to_hold   = w_accept && (r_state != S_IDLE) && !w_frame_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_parity    <= 1'b0;
            r_tx        <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_done <= (r_state == S_STOP) && (r_bitcnt == c_slast) && (r_timer == c_penult);

            if (r_state != S_IDLE) begin
                r_timer <= (r_timer == c_last) ? '0 : r_timer + 1'b1;
            end

            case (r_state)
                S_IDLE: ;
                S_START: if (w_bit_end) begin
                    r_state  <= S_DATA;
                    r_tx     <= r_shift[0];
                    r_shift  <= r_shift >> 1;
                    r_bitcnt <= '0;
                end
                S_DATA: if (w_bit_end) begin
                    if (r_bitcnt == c_dlast) begin
                        r_bitcnt <= '0;
                        if (PARITY != 0) begin
                            r_state <= S_PAR;
                            r_tx    <= r_parity;
                        end else begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_bitcnt <= r_bitcnt + 1'b1;
                        r_tx     <= r_shift[0];
                        r_shift  <= r_shift >> 1;
                    end
                end
                S_PAR: if (w_bit_end) begin
                    r_state  <= S_STOP;
                    r_tx     <= 1'b1;
                    r_bitcnt <= '0;
                end
                S_STOP: if (w_bit_end) begin
                    if (r_bitcnt == c_slast) begin
                        r_state <= S_IDLE;
                        r_tx    <= 1'b1;
                    end else begin
                        r_bitcnt <= r_bitcnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase

            // Loading a word overrides whatever the state branch chose.
            if (w_load) begin
                r_state  <= S_START;
                r_tx     <= 1'b0;
                r_timer  <= '0;
                r_bitcnt <= '0;
                r_shift  <= w_load_word;
                r_parity <= (^w_load_word) ^ c_odd;
            end

            if (w_frame_end && r_hold_full) begin
                r_hold_full <= 1'b0;
            end else if (w_to_hold) begin
                r_hold      <= tx_data;
                r_hold_full <= 1'b1;
            end
        end
    end

    assign tx_ready = ~r_hold_full;
    assign tx_out   = r_tx;
    assign done     = r_done;
    assign busy     = (r_state != S_IDLE) | r_hold_full;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_framer
// Purpose  : Scoreboard bench for uart_tx_framer across four parameter sets.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_framer;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid;
    logic [8:0] data;
    logic [1:0] sel;

    logic [3:0] valid_v;
    logic [3:0] ready_v, tx_v, busy_v, done_v;

    int errors = 0;
    int checks = 0;
    int done_seen = 0;
    int cur_bits, cur_par, cur_stops;
    logic [1:0] exp_q[$];
    logic [1:0] mon_e;

    always #5 clk = ~clk;

    assign valid_v[0] = valid && (sel == 2'd0);
    assign valid_v[1] = valid && (sel == 2'd1);
    assign valid_v[2] = valid && (sel == 2'd2);
    assign valid_v[3] = valid && (sel == 2'd3);

    uart_tx_framer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_none (
        .clk(clk), .rst_n(rst_n), .tx_valid(valid_v[0]), .tx_data(data[7:0]),
        .tx_ready(ready_v[0]), .tx_out(tx_v[0]), .busy(busy_v[0]), .done(done_v[0]));
    uart_tx_framer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_even (
        .clk(clk), .rst_n(rst_n), .tx_valid(valid_v[1]), .tx_data(data[7:0]),
        .tx_ready(ready_v[1]), .tx_out(tx_v[1]), .busy(busy_v[1]), .done(done_v[1]));
    uart_tx_framer #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_odd (
        .clk(clk), .rst_n(rst_n), .tx_valid(valid_v[2]), .tx_data(data[7:0]),
        .tx_ready(ready_v[2]), .tx_out(tx_v[2]), .busy(busy_v[2]), .done(done_v[2]));
    uart_tx_framer #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7b2s (
        .clk(clk), .rst_n(rst_n), .tx_valid(valid_v[3]), .tx_data(data[6:0]),
        .tx_ready(ready_v[3]), .tx_out(tx_v[3]), .busy(busy_v[3]), .done(done_v[3]));

    // Per-clock line monitor: expected {tx_out, done}; idle line when queue empty.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) mon_e = exp_q.pop_front();
        else                  mon_e = 2'b10;
        checks++;
        if ({tx_v[sel], done_v[sel]} !== mon_e) begin
            errors++;
            $display("FAIL line t=%0t dut%0d got tx=%b done=%b expected tx=%b done=%b",
                     $time, sel, tx_v[sel], done_v[sel], mon_e[1], mon_e[0]);
        end
        if (done_v[sel] === 1'b1) done_seen++;
    end

    task automatic push_frame(input logic [8:0] w);
        logic bitq[$];
        logic p;
        bitq.push_back(1'b0);
        p = 1'b0;
        for (int i = 0; i < cur_bits; i++) begin
            bitq.push_back(w[i]);
            p = p ^ w[i];
        end
        if (cur_par != 0) bitq.push_back((cur_par == 1) ? ~p : p);
        for (int s = 0; s < cur_stops; s++) bitq.push_back(1'b1);
        for (int j = 0; j < bitq.size(); j++)
            for (int c = 0; c < CPB; c++)
                exp_q.push_back({bitq[j], (j == bitq.size() - 1) && (c == CPB - 1)});
    endtask

    // Called at a negedge; leaves valid high and returns at the negedge after acceptance.
    task automatic send(input logic [8:0] w);
        int budget = 0;
        valid = 1'b1;
        data  = w;
        while (ready_v[sel] !== 1'b1 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (budget >= 200) begin
            errors++;
            $display("FAIL accept_timeout word=%h got ready=%b required 1", w, ready_v[sel]);
        end else begin
            push_frame(w);
        end
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int budget = 0;
        while (exp_q.size() > 0 && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy_v[sel] !== 1'b0) begin
            errors++;
            $display("FAIL busy_after_frame got %b required 0", busy_v[sel]);
        end
    endtask

    task automatic cfg(input logic [1:0] s, input int b, input int p, input int st);
        sel = s; cur_bits = b; cur_par = p; cur_stops = st;
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if ({tx_v[k], ready_v[k], busy_v[k], done_v[k]} !== 4'b1100) begin
                errors++;
                $display("FAIL reset_state dut%0d got tx/ready/busy/done=%b%b%b%b required 1100",
                         k, tx_v[k], ready_v[k], busy_v[k], done_v[k]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int d0;
        cfg(2'd0, 8, 0, 1);
        d0 = done_seen;
        send(9'h0A5);
        valid = 1'b0;
        checks++;
        if (busy_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL busy_in_frame got %b required 1", busy_v[0]);
        end
        wait_idle();
        checks++;
        if (done_seen - d0 != 1) begin
            errors++;
            $display("FAIL done_count_basic got %0d required 1", done_seen - d0);
        end
    endtask

    task automatic test_parity();
        cfg(2'd1, 8, 2, 1);
        send(9'h007);
        valid = 1'b0;
        wait_idle();
        cfg(2'd2, 8, 1, 1);
        send(9'h003);
        valid = 1'b0;
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int d0;
        cfg(2'd0, 8, 0, 1);
        d0 = done_seen;
        send(9'h011);
        send(9'h022);
        checks++;
        if (ready_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL ready_when_held got %b required 0", ready_v[0]);
        end
        send(9'h033);
        checks++;
        if (done_seen - d0 != 1) begin
            errors++;
            $display("FAIL third_word_timing dones_before_accept got %0d required 1", done_seen - d0);
        end
        // Word offered while full must be dropped without a trace on the line.
        data = 9'h0FF;
        @(negedge clk);
        checks++;
        if (ready_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL ready_ignored_word got %b required 0", ready_v[0]);
        end
        valid = 1'b0;
        wait_idle();
        checks++;
        if (done_seen - d0 != 3) begin
            errors++;
            $display("FAIL done_count_b2b got %0d required 3", done_seen - d0);
        end
    endtask

    task automatic test_7bit_2stop();
        int d0;
        cfg(2'd3, 7, 0, 2);
        d0 = done_seen;
        send(9'h07F);
        valid = 1'b0;
        wait_idle();
        checks++;
        if (done_seen - d0 != 1) begin
            errors++;
            $display("FAIL done_count_2stop got %0d required 1", done_seen - d0);
        end
    endtask

    task automatic test_reset_midframe();
        cfg(2'd0, 8, 0, 1);
        send(9'h000);
        valid = 1'b0;
        repeat (17) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({tx_v[0], ready_v[0], busy_v[0]} !== 3'b110) begin
            errors++;
            $display("FAIL async_reset got tx/ready/busy=%b%b%b required 110",
                     tx_v[0], ready_v[0], busy_v[0]);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        send(9'h05A);
        valid = 1'b0;
        wait_idle();
    endtask

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        data  = '0;
        sel   = 2'd0;
        cur_bits = 8; cur_par = 0; cur_stops = 1;
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_7bit_2stop();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
